sseg_scan_decoder: RTL



---
 rtl/sseg_scan_decoder.sv | 121 ++++++++++++
 1 files changed

// File: rtl/sseg_scan_decoder.sv
// Loopback monitor for a multiplexed active-low seven-segment bus.
// Recovers one BCD digit per anode position once its pattern has been stable long enough.
module sseg_scan_decoder #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4,
    localparam int IW        = (NDIG > 2) ? $clog2(NDIG) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [0:6]        SSeg,
    input  logic [NDIG-1:0]   An,
    output logic [4*NDIG-1:0] BCD,
    output logic [NDIG-1:0]   Valid,
    output logic [NDIG-1:0]   Err,
    output logic              upd,
    output logic [IW-1:0]     upd_idx
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYC);

    logic [NDIG-1:0] samp_an;
    logic [0:6]      samp_seg;
    logic [7:0]      cnt;
    logic            done;

    logic            in_legal;
    logic            same;
    logic            trig;
    logic [IW-1:0]   idx;
    logic [3:0]      gval;
    logic            gok;
    logic            gblank;

    always_comb begin
        in_legal = $onehot(~An);
        same     = (An == samp_an) && (SSeg == samp_seg);
        trig     = (cnt == STABLE) && !done;
    end

    // A trigger only fires for a legal registered sample, so exactly one anode is low here
    always_comb begin
        idx = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (!samp_an[k]) idx = IW'(k);
        end
    end

    always_comb begin
        gval   = 4'hF;
        gok    = 1'b1;
        gblank = 1'b0;
        case (samp_seg)
            7'b0000001: gval = 4'd0;
            7'b1001111: gval = 4'd1;
            7'b0010010: gval = 4'd2;
            7'b0000110: gval = 4'd3;
            7'b1001100: gval = 4'd4;
            7'b0100100: gval = 4'd5;
            7'b0100000: gval = 4'd6;
            7'b0001111: gval = 4'd7;
            7'b0000000: gval = 4'd8;
            7'b0000100: gval = 4'd9;
            7'b1111111: begin
                gok    = 1'b0;
                gblank = 1'b1;
            end
            default: gok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_an  <= '1;
            samp_seg <= '1;
            cnt      <= '0;
            done     <= 1'b0;
            BCD      <= '1;
            Valid    <= '0;
            Err      <= '0;
            upd      <= 1'b0;
            upd_idx  <= '0;
        end else begin
            samp_an  <= An;
            samp_seg <= SSeg;
            upd      <= trig;

            if (!in_legal) begin
                cnt  <= '0;
                done <= 1'b0;
            end else if (!same) begin
                cnt  <= 8'd1;
                done <= 1'b0;
            end else begin
                if (cnt != STABLE) cnt <= cnt + 8'd1;
                if (trig) done <= 1'b1;
            end

            // The write uses the registered sample, so a change arriving on this edge cannot corrupt it
            if (trig) begin
                upd_idx <= idx;
                for (int k = 0; k < NDIG; k++) begin
                    if (idx == IW'(k)) begin
                        if (gok) begin
                            BCD[4*k +: 4] <= gval;
                            Valid[k]      <= 1'b1;
                            Err[k]        <= 1'b0;
                        end else if (gblank) begin
                            BCD[4*k +: 4] <= 4'hF;
                            Valid[k]      <= 1'b0;
                            Err[k]        <= 1'b0;
                        end else begin
                            Valid[k]      <= 1'b0;
                            Err[k]        <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
